hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage RISC-V core.
- Tracks the register-use state of the E, M and W stages internally from the Decode-stage fields. Drives the ForwardAE/ForwardBE selects consumed by the E-stage operand forwarding muxes, plus the StallF/StallD/FlushD/FlushE controls.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard controller for a 5-stage RISC-V pipeline
// Tracks E/M/W register use and drives forwarding selects, stalls, flushes and event counters.
module hazard_ctrl #(
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] Rs1D,
  input  logic [RW-1:0] Rs2D,
  input  logic [RW-1:0] RdD,
  input  logic          RegWriteD,
  input  logic          LoadD,
  input  logic          PCSrcE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount
);

  logic [RW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          reg_write_e, load_e, reg_write_m, reg_write_w;
  logic          lw_stall;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] rs,
    input logic          we_m,
    input logic [RW-1:0] rd_m_i,
    input logic          we_w,
    input logic [RW-1:0] rd_w_i
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m_i != '0) && (rd_m_i == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w_i != '0) && (rd_w_i == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    ForwardBE = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
  end

  always_comb begin
    lw_stall = 1'b0;
    if (load_e && reg_write_e && (rd_e != '0)) begin
      lw_stall = (rd_e == Rs1D) || (rd_e == Rs2D);
    end
    StallF = lw_stall && !PCSrcE;
    StallD = lw_stall && !PCSrcE;
    FlushD = PCSrcE;
    FlushE = lw_stall || PCSrcE;
  end

  // Rd and Load are gated by RegWrite so a non-writing D instruction never carries X into E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else begin
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      if (FlushE) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= Rs1D;
        rs2_e       <= Rs2D;
        rd_e        <= RegWriteD ? RdD : '0;
        reg_write_e <= RegWriteD;
        load_e      <= RegWriteD && LoadD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && !(&StallCount)) begin
        StallCount <= StallCount + CNT_ONE;
      end
      if (FlushD && !(&FlushCount)) begin
        FlushCount <= FlushCount + CNT_ONE;
      end
    end
  end

endmodule
